// File: rtl/div_fifo_drv_pkg.sv
// div_fifo_drv_pkg: shared FSM encoding, LFSR taps, word field positions and result check for div_fifo_driver
package div_fifo_drv_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int OP_DVD_LSB = 8;
    localparam int OP_DVS_LSB = 0;
    localparam int RES_REM_LSB = 8;
    localparam int RES_QUO_LSB = 0;
    localparam logic [7:0] DIVZERO_QUO = 8'hFF;
    function automatic logic div_ok(input logic [7:0] dvd, input logic [7:0] dvs,
                                    input logic [7:0] quo, input logic [7:0] rem);
        return (rem < dvs) && (16'(quo) * 16'(dvs) + 16'(rem) == 16'(dvd));
    endfunction
endpackage

// File: rtl/div_op_queue.sv
// div_op_queue: DEPTH x W FIFO of outstanding operand pairs awaiting their results
module div_op_queue #(
    parameter int DEPTH = 4,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr, r_rd;
    logic         w_wr_en, w_rd_en;
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_head  = r_mem[r_rd[AW-1:0]];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_clr) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + (AW+1)'(1);
            if (w_rd_en) r_rd <= r_rd + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/div_fifo_driver.sv
// div_fifo_driver: LFSR operand generator and result checker for the FIFO-wrapped divider harness.
// DIV_FIFO_DRV_DIVZERO_EN: issue divisor 0 and expect {dividend, 8'hFF}; otherwise divisor 0 becomes 1.
module div_fifo_driver import div_fifo_drv_pkg::*; #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int          DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] num_ops,
    output logic [31:0] in_wdata,
    output logic        in_push,
    input  logic        in_not_full,
    input  logic [31:0] out_rdata,
    input  logic        out_rdy,
    output logic        out_pop,
    output logic        busy,
    output logic        done,
    output logic [15:0] pass_count,
    output logic [15:0] err_count
);
    state_t      r_state, w_next;
    logic [15:0] r_lfsr, r_num_ops, r_issued, r_checked;
    logic        r_chk;
    logic        w_start, w_issue, w_pop, w_ok, w_fb, w_q_full, w_q_empty;
    logic [7:0]  w_dvs_gen, w_dvd, w_dvs, w_quo, w_rem;
    logic [15:0] w_op, w_head;
    logic        w_unused_rdata;
    assign w_unused_rdata = ^out_rdata[31:16];
    assign busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done = (r_state == S_DONE);
    assign w_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // One push every other cycle so in_not_full always reflects the previous push
    assign w_issue = (r_state == S_RUN) && in_not_full && !w_q_full && (r_issued < r_num_ops) && !in_push;
    assign w_pop = out_rdy && !w_q_empty && !out_pop && !r_chk;
    assign w_fb = ^(r_lfsr & LFSR_TAPS);
    assign w_op = {r_lfsr[15:8], w_dvs_gen};
    assign w_dvd = w_head[OP_DVD_LSB +: 8];
    assign w_dvs = w_head[OP_DVS_LSB +: 8];
    assign w_quo = out_rdata[RES_QUO_LSB +: 8];
    assign w_rem = out_rdata[RES_REM_LSB +: 8];
`ifdef DIV_FIFO_DRV_DIVZERO_EN
    assign w_dvs_gen = r_lfsr[7:0];
    assign w_ok = (w_dvs == 8'h00) ? ((w_quo == DIVZERO_QUO) && (w_rem == w_dvd)) : div_ok(w_dvd, w_dvs, w_quo, w_rem);
`else
    assign w_dvs_gen = (r_lfsr[7:0] == 8'h00) ? 8'h01 : r_lfsr[7:0];
    assign w_ok = div_ok(w_dvd, w_dvs, w_quo, w_rem);
`endif
    div_op_queue #(.DEPTH(DEPTH), .W(16)) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_start),
        .i_push  (w_issue),
        .i_pop   (r_chk),
        .i_din   (w_op),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_head  (w_head)
    );
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: if (start) w_next = (num_ops == 16'd0) ? S_DONE : S_RUN;
            S_RUN:          if (r_issued == r_num_ops) w_next = S_DRAIN;
            S_DRAIN:        if (r_checked == r_num_ops) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_lfsr     <= SEED;
            r_num_ops  <= '0;
            r_issued   <= '0;
            r_checked  <= '0;
            r_chk      <= 1'b0;
            in_wdata   <= '0;
            in_push    <= 1'b0;
            out_pop    <= 1'b0;
            pass_count <= '0;
            err_count  <= '0;
        end else begin
            r_state <= w_next;
            in_push <= w_issue;
            out_pop <= w_pop;
            r_chk   <= out_pop;
            if (w_issue) begin
                in_wdata <= {16'h0, w_op};
                r_lfsr   <= {r_lfsr[14:0], w_fb};
                r_issued <= r_issued + 16'd1;
            end
            // out_rdata is valid the cycle after out_pop; r_chk marks that cycle
            if (r_chk) begin
                r_checked <= r_checked + 16'd1;
                if (w_ok) pass_count <= (pass_count == 16'hFFFF) ? pass_count : pass_count + 16'd1;
                else err_count <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
            end
            if (w_start) begin
                r_num_ops  <= num_ops;
                r_lfsr     <= SEED;
                r_issued   <= '0;
                r_checked  <= '0;
                pass_count <= '0;
                err_count  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_div_fifo_driver.sv
// tb_div_fifo_driver: loopback divider harness model plus scenario tasks checked against a reference model
module tb_div_fifo_driver;
    localparam int DEPTH = 4;
`ifdef DIV_FIFO_DRV_DIVZERO_EN
    localparam logic [15:0] SEED = 16'h2A00;
`else
    localparam logic [15:0] SEED = 16'hACE1;
`endif
    logic        clk, reset_n, start, in_push, in_not_full, out_rdy, out_pop, busy, done;
    logic [15:0] num_ops, pass_count, err_count;
    logic [31:0] in_wdata, out_rdata;
    logic        hold, force_rdy, h_rdy;
    int n_chk = 0, n_pass = 0;
    int g_lat = 3, g_corrupt = -1, g_hold_from = -1, g_hold_len = 0, g_ign_k = -1;
    bit g_rand_bp = 0;
    logic [31:0] pushed[$];
    logic [31:0] outq[$];
    logic [31:0] pipe_d[$];
    int pipe_t[$];
    int pops = 0, b2b = 0, cyc = 0;
    logic prev_push = 0;
    logic [7:0] h_dvd, h_dvs, h_q, h_r;
    int base_push, base_pop, base_b2b, first_k, done_k, hold_push, resume_k, max_out;
    bit busy_fall, timed_out;

    assign in_not_full = !hold;
    assign out_rdy = h_rdy | force_rdy;

    div_fifo_driver #(.SEED(SEED), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_ops(num_ops),
        .in_wdata(in_wdata), .in_push(in_push), .in_not_full(in_not_full),
        .out_rdata(out_rdata), .out_rdy(out_rdy), .out_pop(out_pop),
        .busy(busy), .done(done), .pass_count(pass_count), .err_count(err_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Divider harness: computes true quotient/remainder, optionally corrupts one, delivers after g_lat cycles
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_d.delete();
            pipe_t.delete();
            outq.delete();
            pops = pushed.size();
            prev_push = 0;
            h_rdy <= 1'b0;
            out_rdata <= '0;
        end else begin
            cyc++;
            if (in_push) begin
                h_dvd = in_wdata[15:8];
                h_dvs = in_wdata[7:0];
                if (h_dvs == 8'h00) begin h_q = 8'hFF; h_r = h_dvd; end
                else begin h_q = h_dvd / h_dvs; h_r = h_dvd % h_dvs; end
                if (pushed.size() - base_push == g_corrupt) h_q = h_q ^ 8'h01;
                pipe_d.push_back({16'($urandom), h_r, h_q});
                pipe_t.push_back(cyc + g_lat);
                pushed.push_back(in_wdata);
                if (prev_push) b2b++;
            end
            prev_push = in_push;
            if (out_pop) begin
                pops++;
                if (outq.size() != 0) out_rdata <= outq.pop_front();
            end
            while (pipe_t.size() != 0 && pipe_t[0] <= cyc) begin
                outq.push_back(pipe_d.pop_front());
                void'(pipe_t.pop_front());
            end
            h_rdy <= (outq.size() != 0);
        end
    end

    function automatic logic [31:0] ref_op(input int idx);
        logic [15:0] l = SEED;
        logic [7:0] dvs;
        for (int j = 0; j < idx; j++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        dvs = l[7:0];
`ifndef DIV_FIFO_DRV_DIVZERO_EN
        if (dvs == 8'h00) dvs = 8'h01;
`endif
        return {16'h0, l[15:8], dvs};
    endfunction

    task automatic run_ops(input int n);
        int k = 0;
        bit prev_busy = 0;
        base_push = pushed.size(); base_pop = pops; base_b2b = b2b;
        first_k = -1; done_k = -1; hold_push = 0; resume_k = -1; max_out = 0;
        busy_fall = 0; timed_out = 0;
        start = 1; num_ops = 16'(n);
        while (done_k < 0 && !timed_out) begin
            @(negedge clk);
            k++;
            start = (k == g_ign_k);
            if (k == g_ign_k) num_ops = 16'd2;
            if (g_hold_from >= 0) hold = (k >= g_hold_from) && (k < g_hold_from + g_hold_len);
            else if (g_rand_bp) hold = ($urandom_range(0, 3) == 0);
            if (in_push) begin
                if (first_k < 0) first_k = k;
                if (g_hold_from >= 0 && k > g_hold_from && k <= g_hold_from + g_hold_len) hold_push++;
                if (g_hold_from >= 0 && resume_k < 0 && k > g_hold_from + g_hold_len) resume_k = k;
            end
            if (pushed.size() - pops > max_out) max_out = pushed.size() - pops;
            if (done) begin done_k = k; busy_fall = prev_busy && !busy; end
            prev_busy = busy;
            if (k > 5000) timed_out = 1;
        end
        hold = 0;
    endtask

    task automatic test_reset;
        reset_n = 0; start = 0; num_ops = 0; hold = 0; force_rdy = 0;
        repeat (3) @(negedge clk);
        n_chk++; if (in_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", in_wdata); else n_pass++;
        n_chk++; if (in_push !== 1'b0) $display("FAIL reset_push: got %b want 0", in_push); else n_pass++;
        n_chk++; if (out_pop !== 1'b0) $display("FAIL reset_pop: got %b want 0", out_pop); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_chk++; if (pass_count !== 16'd0) $display("FAIL reset_pass: got %0d want 0", pass_count); else n_pass++;
        n_chk++; if (err_count !== 16'd0) $display("FAIL reset_err: got %0d want 0", err_count); else n_pass++;
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int mism = 0;
        g_lat = 3; g_corrupt = -1;
        run_ops(10);
        for (int i = 0; i < 10 && base_push + i < pushed.size(); i++)
            if (pushed[base_push + i] !== ref_op(i)) mism++;
        n_chk++; if (timed_out) $display("FAIL basic_timeout: got timeout want done"); else n_pass++;
        n_chk++; if (pushed.size() - base_push != 10) $display("FAIL basic_pushes: got %0d want 10", pushed.size() - base_push); else n_pass++;
        n_chk++; if (mism != 0) $display("FAIL basic_wdata: got %0d mismatched words want 0", mism); else n_pass++;
        n_chk++; if (first_k != 2) $display("FAIL basic_first_push: got cycle %0d want 2", first_k); else n_pass++;
        n_chk++; if (pass_count !== 16'd10) $display("FAIL basic_pass: got %0d want 10", pass_count); else n_pass++;
        n_chk++; if (err_count !== 16'd0) $display("FAIL basic_err: got %0d want 0", err_count); else n_pass++;
        n_chk++; if (!busy_fall) $display("FAIL basic_busy_fall: got busy=%b at done want busy falling with done", busy); else n_pass++;
        n_chk++; if (b2b != base_b2b) $display("FAIL basic_b2b_push: got %0d back-to-back pushes want 0", b2b - base_b2b); else n_pass++;
        n_chk++; if (pops - base_pop != 10) $display("FAIL basic_pops: got %0d want 10", pops - base_pop); else n_pass++;
    endtask

    task automatic test_corrupt;
        g_lat = 3; g_corrupt = 3;
        run_ops(8);
        g_corrupt = -1;
        n_chk++; if (timed_out) $display("FAIL corrupt_timeout: got timeout want done"); else n_pass++;
        n_chk++; if (err_count !== 16'd1) $display("FAIL corrupt_err: got %0d want 1", err_count); else n_pass++;
        n_chk++; if (pass_count !== 16'd7) $display("FAIL corrupt_pass: got %0d want 7", pass_count); else n_pass++;
    endtask

    task automatic test_backpressure;
        g_lat = 3; g_hold_from = 8; g_hold_len = 20;
        run_ops(16);
        n_chk++; if (hold_push != 0) $display("FAIL hold_push: got %0d pushes while full want 0", hold_push); else n_pass++;
        n_chk++; if (resume_k != g_hold_from + g_hold_len + 1) $display("FAIL hold_resume: got cycle %0d want %0d", resume_k, g_hold_from + g_hold_len + 1); else n_pass++;
        n_chk++; if (pass_count !== 16'd16) $display("FAIL hold_pass: got %0d want 16", pass_count); else n_pass++;
        n_chk++; if (err_count !== 16'd0) $display("FAIL hold_err: got %0d want 0", err_count); else n_pass++;
        g_hold_from = -1; g_hold_len = 0;
    endtask

    task automatic test_long_latency;
        int p0;
        g_lat = 50;
        run_ops(12);
        n_chk++; if (timed_out) $display("FAIL lat_timeout: got timeout want done"); else n_pass++;
        n_chk++; if (max_out != DEPTH) $display("FAIL lat_outstanding: got max %0d want %0d", max_out, DEPTH); else n_pass++;
        n_chk++; if (pass_count !== 16'd12) $display("FAIL lat_pass: got %0d want 12", pass_count); else n_pass++;
        p0 = pops;
        force_rdy = 1;
        repeat (10) @(negedge clk);
        force_rdy = 0;
        n_chk++; if (pops != p0) $display("FAIL empty_no_pop: got %0d pops want 0", pops - p0); else n_pass++;
        g_lat = 3;
    endtask

    task automatic test_zero_and_ignore;
        run_ops(0);
        n_chk++; if (done_k < 1 || done_k > 2) $display("FAIL zero_done: got done at cycle %0d want 1..2", done_k); else n_pass++;
        n_chk++; if (pushed.size() != base_push) $display("FAIL zero_push: got %0d want 0", pushed.size() - base_push); else n_pass++;
        n_chk++; if (pops != base_pop) $display("FAIL zero_pop: got %0d want 0", pops - base_pop); else n_pass++;
        g_ign_k = 5;
        run_ops(6);
        g_ign_k = -1;
        n_chk++; if (pushed.size() - base_push != 6) $display("FAIL ignore_pushes: got %0d want 6", pushed.size() - base_push); else n_pass++;
        n_chk++; if (pass_count !== 16'd6) $display("FAIL ignore_pass: got %0d want 6", pass_count); else n_pass++;
    endtask

    task automatic test_reset_midrun;
        g_lat = 3;
        start = 1; num_ops = 16'd20;
        @(negedge clk);
        start = 0;
        repeat (12) @(negedge clk);
        reset_n = 0;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (in_wdata !== 32'h0) $display("FAIL midrst_wdata: got %h want 0", in_wdata); else n_pass++;
        n_chk++; if (in_push !== 1'b0 || out_pop !== 1'b0) $display("FAIL midrst_strobes: got push=%b pop=%b want 0 0", in_push, out_pop); else n_pass++;
        n_chk++; if (pass_count !== 16'd0 || err_count !== 16'd0) $display("FAIL midrst_counts: got %0d/%0d want 0/0", pass_count, err_count); else n_pass++;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        run_ops(3);
        n_chk++; if (pushed.size() <= base_push || pushed[base_push] !== ref_op(0)) $display("FAIL midrst_first_word: got %h want %h", (pushed.size() > base_push) ? pushed[base_push] : 32'hx, ref_op(0)); else n_pass++;
        n_chk++; if (pass_count !== 16'd3) $display("FAIL midrst_pass: got %0d want 3", pass_count); else n_pass++;
    endtask

    task automatic test_random;
        int n, ee, mism;
        g_rand_bp = 1;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(5, 30);
            g_lat = $urandom_range(1, 12);
            g_corrupt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            ee = (g_corrupt >= 0) ? 1 : 0;
            run_ops(n);
            mism = 0;
            for (int i = 0; i < n && base_push + i < pushed.size(); i++)
                if (pushed[base_push + i] !== ref_op(i)) mism++;
            n_chk++; if (pushed.size() - base_push != n || mism != 0) $display("FAIL rand%0d_stream: got %0d pushes %0d bad want %0d 0", r, pushed.size() - base_push, mism, n); else n_pass++;
            n_chk++; if (pass_count !== 16'(n - ee)) $display("FAIL rand%0d_pass: got %0d want %0d", r, pass_count, n - ee); else n_pass++;
            n_chk++; if (err_count !== 16'(ee)) $display("FAIL rand%0d_err: got %0d want %0d", r, err_count, ee); else n_pass++;
            n_chk++; if (timed_out || b2b != base_b2b) $display("FAIL rand%0d_flow: got timeout=%0d b2b=%0d want 0 0", r, timed_out, b2b - base_b2b); else n_pass++;
        end
        g_rand_bp = 0; g_corrupt = -1; g_lat = 3;
    endtask

`ifdef DIV_FIFO_DRV_DIVZERO_EN
    task automatic test_divzero;
        run_ops(1);
        n_chk++; if (pushed[base_push] !== 32'h00002A00) $display("FAIL divzero_word: got %h want 00002a00", pushed[base_push]); else n_pass++;
        n_chk++; if (pass_count !== 16'd1 || err_count !== 16'd0) $display("FAIL divzero_check: got %0d/%0d want 1/0", pass_count, err_count); else n_pass++;
    endtask
`endif

    initial begin
        base_push = 0;
        test_reset;
        test_basic;
        test_corrupt;
        test_backpressure;
        test_long_latency;
        test_zero_and_ignore;
        test_reset_midrun;
        test_random;
`ifdef DIV_FIFO_DRV_DIVZERO_EN
        test_divzero;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
